// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master with framed multi-word transfers, selectable
// slave select and CPOL/CPHA modes.
//
// Ports:
//   clk, rst_n             system clock, asynchronous active-low reset
//   spi_tx_data/last/dest  word, end-of-frame flag, slave index (first word only)
//   spi_tx_valid/ready     input stream handshake
//   spi_rx_data/valid      received word, one-cycle qualifier
//   SCK_*, SS_*, IO0_*     SPI clock, slave selects, MOSI as tristate pairs
//   IO1_*                  MISO (IO1_I sampled, IO1_O/IO1_T parked as input)
//
// Build option: define SPI_MASTER_LSB_FIRST_EN to shift words LSB first
// (default is MSB first). Ports are identical in both builds.
module spi_master_multi #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_RATIO  = 16,
  parameter int unsigned NUM_SS     = 1,
  parameter bit          CPOL       = 1'b0,
  parameter bit          CPHA       = 1'b0
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [DATA_WIDTH-1:0]                        spi_tx_data,
  input  logic                                         spi_tx_last,
  input  logic [((NUM_SS > 1) ? $clog2(NUM_SS) : 1)-1:0] spi_tx_dest,
  input  logic                                         spi_tx_valid,
  output logic                                         spi_tx_ready,
  output logic [DATA_WIDTH-1:0]                        spi_rx_data,
  output logic                                         spi_rx_valid,
  input  logic                                         SCK_I,
  output logic                                         SCK_O,
  output logic                                         SCK_T,
  input  logic [NUM_SS-1:0]                            SS_I,
  output logic [NUM_SS-1:0]                            SS_O,
  output logic                                         SS_T,
  input  logic                                         IO0_I,
  output logic                                         IO0_O,
  output logic                                         IO0_T,
  input  logic                                         IO1_I,
  output logic                                         IO1_O,
  output logic                                         IO1_T
);

`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  localparam int unsigned DEST_W      = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
  localparam int unsigned HALF        = CLK_RATIO / 2;
  localparam int unsigned CNT_W       = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned EDGE_W      = $clog2(2 * DATA_WIDTH);
  localparam int unsigned LAST_EDGE   = 2 * DATA_WIDTH - 1;
  // CPHA=0 samples on leading (even) edges, CPHA=1 on trailing (odd) edges
  localparam int unsigned LAST_SAMPLE = CPHA ? (2 * DATA_WIDTH - 1) : (2 * DATA_WIDTH - 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_TRAIL = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  function automatic logic out_bit(input logic [DATA_WIDTH-1:0] v);
    return LSB_FIRST ? v[0] : v[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_tx(input logic [DATA_WIDTH-1:0] v);
    return LSB_FIRST ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_rx(input logic [DATA_WIDTH-1:0] v, input logic b);
    return LSB_FIRST ? {b, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], b};
  endfunction

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [EDGE_W-1:0]     edge_q, edge_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  ready_q, ready_d;
  logic                  sck_q, sck_d;
  logic                  io0_q, io0_d;
  logic [NUM_SS-1:0]     ss_q, ss_d;
  logic                  last_q, last_d;
  logic                  rst_done_q;
  logic [NUM_SS-1:0]     ss_dec;
  logic [DATA_WIDTH-1:0] rx_next;
  logic                  half_done;
  logic                  handshake;

  assign half_done = (cnt_q == CNT_W'(HALF - 1));
  assign handshake = spi_tx_valid && ready_q;
  assign rx_next   = shift_rx(rx_sh_q, IO1_I);

  // Slave-select decode; an out-of-range index leaves every select high
  always_comb begin
    ss_dec = '1;
    for (int unsigned i = 0; i < NUM_SS; i++) begin
      ss_dec[i] = (spi_tx_dest != DEST_W'(i));
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sck_d      = sck_q;
    io0_d      = io0_q;
    ss_d       = ss_q;
    last_d     = last_q;

    case (state_q)
      S_IDLE, S_HOLD: begin
        cnt_d = '0;
        if (handshake) begin
          tx_sh_d = spi_tx_data;
          last_d  = spi_tx_last;
          // First bit must be on MOSI before the first leading edge when CPHA=0
          if (!CPHA) io0_d = out_bit(spi_tx_data);
          // Slave select only follows dest at the start of a frame
          if (state_q == S_IDLE) ss_d = ss_dec;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (half_done) begin
          cnt_d   = '0;
          edge_d  = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (half_done) begin
          cnt_d  = '0;
          sck_d  = ~sck_q;
          edge_d = edge_q + EDGE_W'(1);
          if (edge_q[0] == CPHA) begin
            rx_sh_d = rx_next;
            if (edge_q == EDGE_W'(LAST_SAMPLE)) begin
              rx_data_d  = rx_next;
              rx_valid_d = 1'b1;
            end
          end else if (CPHA) begin
            io0_d   = out_bit(tx_sh_q);
            tx_sh_d = shift_tx(tx_sh_q);
          end else if (edge_q != EDGE_W'(LAST_EDGE)) begin
            tx_sh_d = shift_tx(tx_sh_q);
            io0_d   = out_bit(shift_tx(tx_sh_q));
          end
          if (edge_q == EDGE_W'(LAST_EDGE)) begin
            state_d = last_q ? S_TRAIL : S_HOLD;
          end
        end
      end
      S_TRAIL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (half_done) begin
          cnt_d   = '0;
          ss_d    = '1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (half_done) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        ss_d    = '1;
        sck_d   = CPOL;
        cnt_d   = '0;
      end
    endcase

    // Ready is held off for one cycle after reset release
    ready_d = rst_done_q && ((state_d == S_IDLE) || (state_d == S_HOLD));
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      edge_q     <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      sck_q      <= CPOL;
      io0_q      <= 1'b0;
      ss_q       <= '1;
      last_q     <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ready_q    <= ready_d;
      sck_q      <= sck_d;
      io0_q      <= io0_d;
      ss_q       <= ss_d;
      last_q     <= last_d;
      rst_done_q <= 1'b1;
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{SCK_I, SS_I, IO0_I};

  assign spi_tx_ready = ready_q;
  assign spi_rx_data  = rx_data_q;
  assign spi_rx_valid = rx_valid_q;
  assign SCK_O        = sck_q;
  assign SCK_T        = 1'b0;
  assign SS_O         = ss_q;
  assign SS_T         = 1'b0;
  assign IO0_O        = io0_q;
  assign IO0_T        = 1'b0;
  assign IO1_O        = 1'b0;
  assign IO1_T        = 1'b1;

endmodule
